// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared micro-BTB entry type, counter encodings and tag fold
package bpu_pkg;

  // Field widths of the stored entry; wide enough for any supported configuration.
  localparam int TAG_MAX  = 32;
  localparam int SLOT_MAX = 8;
  localparam int XLEN_MAX = 64;

  // 2-bit saturating direction counter encodings; ctr[1] is the taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [TAG_MAX-1:0]  tag;
    logic [SLOT_MAX-1:0] slot;
    logic [XLEN_MAX-1:0] target;
    logic [1:0]          ctr;
  } ubtb_entry_t;

  // XOR-fold the bits above the index down to tag_len bits; bit i lands on i mod tag_len.
  function automatic logic [TAG_MAX-1:0] fold_tag(input logic [XLEN_MAX-1:0] hi,
                                                  input int tag_len);
    logic [TAG_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < XLEN_MAX; i++) begin
      r[5'(i % tag_len)] = r[5'(i % tag_len)] ^ hi[i];
    end
    return r;
  endfunction

  // Saturating counter step toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'b01;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/ubtb_way_sel.sv
// rtl/ubtb_way_sel.sv - allocation victim choice: lowest invalid way, else round-robin pointer
module ubtb_way_sel #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_rr_ptr,
  output logic [WAY_W-1:0] o_way,
  output logic             o_full
);

  logic [WAY_W-1:0] w_way;

  // Scan from the top down so the lowest-numbered invalid way wins.
  always_comb begin
    w_way = i_rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) w_way = WAY_W'(w);
    end
  end

  assign o_way  = w_way;
  assign o_full = &i_valid;

endmodule

// File: rtl/ubtb_sa.sv
// rtl/ubtb_sa.sv - set-associative micro-BTB with 1-cycle lookup and in-place update
module ubtb_sa
  import bpu_pkg::*;
#(
  parameter int MXLEN   = 32,
  parameter int SETS    = 16,
  parameter int WAYS    = 4,
  parameter int FETCH_W = 2,
  parameter int TAG_LEN = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_lkp_valid,
  input  logic [MXLEN-1:0]           i_lkp_pc,
  output logic                       o_pred_valid,
  output logic                       o_pred_hit,
  output logic                       o_pred_taken,
  output logic [$clog2(FETCH_W)-1:0] o_pred_slot,
  output logic [MXLEN-1:0]           o_pred_target,
  input  logic                       i_upd_valid,
  input  logic [MXLEN-1:0]           i_upd_pc,
  input  logic                       i_upd_taken,
  input  logic [MXLEN-1:0]           i_upd_target,
  input  logic                       i_flush
);

  localparam int SLOT_W = $clog2(FETCH_W);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG_SH = 2 + SLOT_W + IDX_W;

  ubtb_entry_t      r_tab [SETS][WAYS];
  logic [WAY_W-1:0] r_rr  [SETS];

  logic                r_pred_valid, r_pred_hit, r_pred_taken;
  logic [SLOT_W-1:0]   r_pred_slot;
  logic [MXLEN-1:0]    r_pred_target;

  // Address split for lookup and update.
  logic [SLOT_W-1:0]  w_l_slot, w_u_slot;
  logic [IDX_W-1:0]   w_l_idx,  w_u_idx;
  logic [TAG_MAX-1:0] w_l_tag,  w_u_tag;

  assign w_l_slot = i_lkp_pc[2 +: SLOT_W];
  assign w_l_idx  = i_lkp_pc[2 + SLOT_W +: IDX_W];
  assign w_l_tag  = fold_tag(XLEN_MAX'(i_lkp_pc) >> TAG_SH, TAG_LEN);
  assign w_u_slot = i_upd_pc[2 +: SLOT_W];
  assign w_u_idx  = i_upd_pc[2 + SLOT_W +: IDX_W];
  assign w_u_tag  = fold_tag(XLEN_MAX'(i_upd_pc) >> TAG_SH, TAG_LEN);

  // Lookup qualification: valid, same tag in the indexed set, branch at or after fetch slot.
  logic [WAYS-1:0] w_l_qual;
  always_comb begin
    w_l_qual = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_l_qual[w] = r_tab[w_l_idx][w].valid && (r_tab[w_l_idx][w].tag == w_l_tag) &&
                    (r_tab[w_l_idx][w].slot >= SLOT_MAX'(w_l_slot));
    end
  end

  // Among qualifying taken-predicting entries pick the earliest slot in the group.
  logic                w_l_hit, w_l_taken;
  logic [SLOT_MAX-1:0] w_l_best_slot;
  logic [XLEN_MAX-1:0] w_l_best_tgt;
  always_comb begin
    w_l_hit       = |w_l_qual;
    w_l_taken     = 1'b0;
    w_l_best_slot = '0;
    w_l_best_tgt  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_l_qual[w] && r_tab[w_l_idx][w].ctr[1] &&
          (!w_l_taken || (r_tab[w_l_idx][w].slot < w_l_best_slot))) begin
        w_l_taken     = 1'b1;
        w_l_best_slot = r_tab[w_l_idx][w].slot;
        w_l_best_tgt  = r_tab[w_l_idx][w].target;
      end
    end
  end

  // Update match search; duplicates are never created, so at most one way matches.
  logic [WAYS-1:0]  w_u_valid_vec;
  logic             w_u_hit;
  logic [WAY_W-1:0] w_u_mway;
  always_comb begin
    w_u_valid_vec = '0;
    w_u_hit       = 1'b0;
    w_u_mway      = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_u_valid_vec[w] = r_tab[w_u_idx][w].valid;
      if (r_tab[w_u_idx][w].valid && (r_tab[w_u_idx][w].tag == w_u_tag) &&
          (r_tab[w_u_idx][w].slot == SLOT_MAX'(w_u_slot))) begin
        w_u_hit  = 1'b1;
        w_u_mway = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0] w_vway;
  logic             w_full;

  ubtb_way_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_way_sel (
    .i_valid  (w_u_valid_vec),
    .i_rr_ptr (r_rr[w_u_idx]),
    .o_way    (w_vway),
    .o_full   (w_full)
  );

  // Table write: flush beats update; matches train in place, taken misses allocate.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tab[s][w].valid <= 1'b0;
          r_tab[s][w].ctr   <= CTR_SNT;
        end
      end
    end else if (i_flush) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_tab[s][w].valid <= 1'b0;
      end
    end else if (i_upd_valid) begin
      if (w_u_hit) begin
        r_tab[w_u_idx][w_u_mway].ctr <= ctr_next(r_tab[w_u_idx][w_u_mway].ctr, i_upd_taken);
        if (i_upd_taken) r_tab[w_u_idx][w_u_mway].target <= XLEN_MAX'(i_upd_target);
      end else if (i_upd_taken) begin
        r_tab[w_u_idx][w_vway] <= '{valid: 1'b1, tag: w_u_tag, slot: SLOT_MAX'(w_u_slot),
                                    target: XLEN_MAX'(i_upd_target), ctr: CTR_WT};
        if (w_full) r_rr[w_u_idx] <= r_rr[w_u_idx] + WAY_W'(1);
      end
    end
  end

  // Registered prediction outputs, all zero unless a lookup was presented.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_slot   <= '0;
      r_pred_target <= '0;
    end else begin
      r_pred_valid  <= i_lkp_valid;
      r_pred_hit    <= i_lkp_valid && w_l_hit;
      r_pred_taken  <= i_lkp_valid && w_l_taken;
      r_pred_slot   <= (i_lkp_valid && w_l_taken) ? w_l_best_slot[SLOT_W-1:0] : '0;
      r_pred_target <= (i_lkp_valid && w_l_taken) ? w_l_best_tgt[MXLEN-1:0]   : '0;
    end
  end

  assign o_pred_valid  = r_pred_valid;
  assign o_pred_hit    = r_pred_hit;
  assign o_pred_taken  = r_pred_taken;
  assign o_pred_slot   = r_pred_slot;
  assign o_pred_target = r_pred_target;

endmodule

// File: tb/tb_ubtb_sa.sv
// tb/tb_ubtb_sa.sv - directed self-checking bench for the micro-BTB
module tb_ubtb_sa;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_lkp_valid = 1'b0;
  logic [31:0] i_lkp_pc = '0;
  logic        o_pred_valid, o_pred_hit, o_pred_taken;
  logic [0:0]  o_pred_slot;
  logic [31:0] o_pred_target;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic        i_upd_taken = 1'b0;
  logic [31:0] i_upd_target = '0;
  logic        i_flush = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // {valid, hit, taken, slot, target}
  logic [35:0] w_obs;
  assign w_obs = {o_pred_valid, o_pred_hit, o_pred_taken, o_pred_slot, o_pred_target};

  localparam logic [35:0] MISS = 36'h8_0000_0000;
  localparam logic [35:0] HNT  = 36'hC_0000_0000;
  localparam logic [35:0] IDLE = 36'h0_0000_0000;

  always #5 i_clk = ~i_clk;

  ubtb_sa dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_lkp_valid  (i_lkp_valid),
    .i_lkp_pc     (i_lkp_pc),
    .o_pred_valid (o_pred_valid),
    .o_pred_hit   (o_pred_hit),
    .o_pred_taken (o_pred_taken),
    .o_pred_slot  (o_pred_slot),
    .o_pred_target(o_pred_target),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .i_upd_target (i_upd_target),
    .i_flush      (i_flush)
  );

  task automatic lookup(input logic [31:0] pc);
    i_lkp_valid = 1'b1;
    i_lkp_pc    = pc;
    @(posedge i_clk); #1;
    i_lkp_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    i_upd_valid  = 1'b1;
    i_upd_pc     = pc;
    i_upd_taken  = tk;
    i_upd_target = tgt;
    @(posedge i_clk); #1;
    i_upd_valid  = 1'b0;
  endtask

  task automatic flush;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
  endtask

  task automatic test_reset;
    i_rstn      = 1'b0;
    i_lkp_valid = 1'b1;
    i_lkp_pc    = 32'h1000;
    @(posedge i_clk); #1;
    n_chk++;
    if (w_obs !== IDLE) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", w_obs, IDLE);
    end
    i_lkp_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL post_reset_lookup: got %h expected %h", w_obs, MISS);
    end
    @(posedge i_clk); #1;
    n_chk++;
    if (w_obs !== IDLE) begin
      n_fail++; $display("FAIL idle_outputs: got %h expected %h", w_obs, IDLE);
    end
  endtask

  task automatic test_basic_hit;
    upd(32'h1004, 1'b1, 32'h2000);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== 36'hF_0000_2000) begin
      n_fail++; $display("FAIL basic_hit_slot0: got %h expected %h", w_obs, 36'hF_0000_2000);
    end
    lookup(32'h1004);
    n_chk++;
    if (w_obs !== 36'hF_0000_2000) begin
      n_fail++; $display("FAIL basic_hit_slot1: got %h expected %h", w_obs, 36'hF_0000_2000);
    end
    lookup(32'h1008);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL basic_other_set: got %h expected %h", w_obs, MISS);
    end
    lookup(32'h1084);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL basic_other_tag: got %h expected %h", w_obs, MISS);
    end
    flush;
  endtask

  task automatic test_slot_priority;
    upd(32'h1000, 1'b1, 32'h3000);
    upd(32'h1004, 1'b1, 32'h4000);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== 36'hE_0000_3000) begin
      n_fail++; $display("FAIL slot_lowest: got %h expected %h", w_obs, 36'hE_0000_3000);
    end
    lookup(32'h1004);
    n_chk++;
    if (w_obs !== 36'hF_0000_4000) begin
      n_fail++; $display("FAIL slot_skip_earlier: got %h expected %h", w_obs, 36'hF_0000_4000);
    end
    upd(32'h1000, 1'b0, 32'h0);
    upd(32'h1000, 1'b0, 32'h0);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== 36'hF_0000_4000) begin
      n_fail++; $display("FAIL slot_nt_then_taken: got %h expected %h", w_obs, 36'hF_0000_4000);
    end
    flush;
    upd(32'h1000, 1'b1, 32'h3000);
    lookup(32'h1004);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL slot_before_fetch: got %h expected %h", w_obs, MISS);
    end
    flush;
  endtask

  task automatic test_counter;
    upd(32'h1004, 1'b1, 32'h2000);
    upd(32'h1004, 1'b0, 32'h0);
    upd(32'h1004, 1'b0, 32'h0);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== HNT) begin
      n_fail++; $display("FAIL ctr_two_nt: got %h expected %h", w_obs, HNT);
    end
    upd(32'h1004, 1'b0, 32'h0);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== HNT) begin
      n_fail++; $display("FAIL ctr_sat_low: got %h expected %h", w_obs, HNT);
    end
    upd(32'h1004, 1'b1, 32'h2000);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== HNT) begin
      n_fail++; $display("FAIL ctr_one: got %h expected %h", w_obs, HNT);
    end
    upd(32'h1004, 1'b1, 32'h5000);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== 36'hF_0000_5000) begin
      n_fail++; $display("FAIL ctr_two_new_target: got %h expected %h", w_obs, 36'hF_0000_5000);
    end
    upd(32'h1004, 1'b1, 32'h5000);
    upd(32'h1004, 1'b1, 32'h5000);
    upd(32'h1004, 1'b0, 32'h0);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== 36'hF_0000_5000) begin
      n_fail++; $display("FAIL ctr_sat_high: got %h expected %h", w_obs, 36'hF_0000_5000);
    end
    upd(32'h1004, 1'b0, 32'h0);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== HNT) begin
      n_fail++; $display("FAIL ctr_back_to_one: got %h expected %h", w_obs, HNT);
    end
    flush;
    upd(32'h1004, 1'b0, 32'h2000);
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL nt_miss_no_alloc: got %h expected %h", w_obs, MISS);
    end
  endtask

  task automatic test_alias;
    logic [35:0] exp;
    flush;
    for (int k = 0; k < 5; k++) upd(32'h1004 + 32'(k) * 32'h80, 1'b1, 32'h6000 + 32'(k) * 32'h10);
    lookup(32'h1004);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL alias_first_evicted: got %h expected %h", w_obs, MISS);
    end
    for (int k = 1; k < 5; k++) begin
      lookup(32'h1004 + 32'(k) * 32'h80);
      exp = {4'hF, 32'h6000 + 32'(k) * 32'h10};
      n_chk++;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL alias_keep_%0d: got %h expected %h", k, w_obs, exp);
      end
    end
    upd(32'h1004 + 32'h280, 1'b1, 32'h7000);
    lookup(32'h1004 + 32'h80);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL alias_rr_advance: got %h expected %h", w_obs, MISS);
    end
    lookup(32'h1004 + 32'h100);
    n_chk++;
    if (w_obs !== 36'hF_0000_6020) begin
      n_fail++; $display("FAIL alias_rr_keep: got %h expected %h", w_obs, 36'hF_0000_6020);
    end
    flush;
  endtask

  task automatic test_back_to_back;
    i_upd_valid  = 1'b1;
    i_upd_pc     = 32'h1004;
    i_upd_taken  = 1'b1;
    i_upd_target = 32'h2000;
    lookup(32'h1004);
    i_upd_valid  = 1'b0;
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL same_cycle_no_bypass: got %h expected %h", w_obs, MISS);
    end
    lookup(32'h1004);
    n_chk++;
    if (w_obs !== 36'hF_0000_2000) begin
      n_fail++; $display("FAIL same_cycle_next_hit: got %h expected %h", w_obs, 36'hF_0000_2000);
    end
  endtask

  task automatic test_flush_vs_update;
    i_upd_valid  = 1'b1;
    i_upd_pc     = 32'h1084;
    i_upd_taken  = 1'b1;
    i_upd_target = 32'h2100;
    flush;
    i_upd_valid  = 1'b0;
    lookup(32'h1004);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL flush_clears: got %h expected %h", w_obs, MISS);
    end
    lookup(32'h1084);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL flush_wins: got %h expected %h", w_obs, MISS);
    end
  endtask

  task automatic test_reset_mid_update;
    i_upd_valid  = 1'b1;
    i_upd_pc     = 32'h1004;
    i_upd_taken  = 1'b1;
    i_upd_target = 32'h2000;
    #2 i_rstn = 1'b0;
    @(posedge i_clk); #1;
    i_upd_valid = 1'b0;
    i_rstn      = 1'b1;
    lookup(32'h1000);
    n_chk++;
    if (w_obs !== MISS) begin
      n_fail++; $display("FAIL reset_discards_update: got %h expected %h", w_obs, MISS);
    end
  endtask

  initial begin
    test_reset;
    test_basic_hit;
    test_slot_priority;
    test_counter;
    test_alias;
    test_back_to_back;
    test_flush_vs_update;
    test_reset_mid_update;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
